// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares the single data RAM port between the core (m0)
// and a debug/program-loader port (m1). The core has priority, a starvation
// counter bounds how long m1 can wait, and a lock mode hands m1 exclusive
// ownership for bulk loads while the core is held stalled.
module ram_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_rd_req_i,
    input  logic [ADDR_W-1:0] m0_rd_addr_i,
    input  logic              m0_wr_req_i,
    input  logic [3:0]        m0_wr_sel_i,
    input  logic [ADDR_W-1:0] m0_wr_addr_i,
    input  logic [DATA_W-1:0] m0_wr_data_i,
    output logic [DATA_W-1:0] m0_rd_data_o,
    output logic              m0_stall_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [3:0]        ram_wen_o,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_w_data_o,
    output logic              ram_ren_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0] ram_r_data_i,
    output logic              owner_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        S_NORM = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        starve_cnt;
    logic [7:0]        starve_nxt;
    logic              m0_active;
    logic              starved;
    logic              gnt;
    logic              stall;
    logic              owner;
    logic              rvld_p1;
    logic [DATA_W-1:0] rdata_hold_p1;

    // Saturating increment: the counter parks at the limit instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= LIMIT) ? LIMIT : v + 8'd1;
    endfunction

    assign m0_active = m0_rd_req_i | (m0_wr_req_i & (|m0_wr_sel_i));
    assign starved   = (starve_cnt == LIMIT);

    // State register and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_NORM;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next-state logic: enter lock on a locked m1 grant, leave when lock drops.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            S_NORM: begin
                if (gnt && m1_lock_i) state_nxt = S_LOCK;
                // A waiting m1 that was not granted lost to an active core.
                if (!m1_req_i || gnt) starve_nxt = 8'd0;
                else                  starve_nxt = sat_inc(starve_cnt);
            end
            S_LOCK: begin
                starve_nxt = 8'd0;
                if (!m1_lock_i) state_nxt = S_NORM;
            end
            default: begin
                state_nxt  = S_NORM;
                starve_nxt = 8'd0;
            end
        endcase
    end

    // Output logic: who owns the port this cycle, and whether the core stalls.
    always_comb begin
        gnt   = 1'b0;
        stall = 1'b0;
        owner = 1'b0;
        if (!rst) begin
            case (state)
                S_NORM: begin
                    if (m1_req_i && (!m0_active || starved)) begin
                        gnt   = 1'b1;
                        owner = 1'b1;
                        stall = m0_active;
                    end
                end
                S_LOCK: begin
                    owner = 1'b1;
                    gnt   = m1_req_i;
                    stall = m0_active;
                end
                default: begin
                    owner = 1'b0;
                end
            endcase
        end
    end

    // RAM port mux; the core path is a pure pass-through when it owns the port.
    always_comb begin
        ram_wen_o    = 4'b0;
        ram_ren_o    = 1'b0;
        ram_w_addr_o = m0_wr_addr_i;
        ram_w_data_o = m0_wr_data_i;
        ram_r_addr_o = m0_rd_addr_i;
        if (owner) begin
            ram_w_addr_o = m1_addr_i;
            ram_w_data_o = m1_wdata_i;
            ram_r_addr_o = m1_addr_i;
            if (gnt) begin
                if (m1_we_i) ram_wen_o = m1_sel_i;
                else         ram_ren_o = 1'b1;
            end
        end else if (!rst) begin
            ram_wen_o = m0_wr_req_i ? m0_wr_sel_i : 4'b0;
            ram_ren_o = m0_rd_req_i;
        end
    end

    // m1 read response: valid one cycle after the grant, data held until the next valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvld_p1       <= 1'b0;
            rdata_hold_p1 <= '0;
        end else begin
            rvld_p1 <= gnt & ~m1_we_i;
            if (rvld_p1) rdata_hold_p1 <= ram_r_data_i;
        end
    end

    assign m0_rd_data_o = ram_r_data_i;
    assign m0_stall_o   = stall;
    assign m1_gnt_o     = gnt;
    assign owner_o      = owner;
    assign m1_rvalid_o  = rvld_p1;
    assign m1_rdata_o   = rvld_p1 ? ram_r_data_i : rdata_hold_p1;

endmodule
